// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the readout-FIFO write scheduler.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE_s,
    HDR_s,
    DATA_s
  } sched_state_t;

  // Upper nibble of every block header byte; lower nibble carries the channel id.
  localparam logic [3:0] HDR_SYNC = 4'hA;

  // Widest request vector the pick helper handles (grant ids are 4 bits).
  localparam int unsigned MAX_CH = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First requesting index at or after ptr, wrapping modulo nch.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                       input logic [3:0]        ptr,
                                       input int unsigned       nch);
    rr_pick_t    r;
    int unsigned cand;
    r = '0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= nch) cand = cand - nch;
      if ((k < nch) && !r.found && req[cand[3:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_sched_rr_arbiter.sv
// Round-robin channel picker: combinational pick plus the rotating start pointer.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic           clk,
  input  logic           arstn,
  input  logic [NCH-1:0] req,
  input  logic           adv,
  input  logic [3:0]     last_id,
  output logic           found,
  output logic [3:0]     pick
);

  logic [3:0] rr_ptr;
  rr_pick_t   sel;

  // Winner search starting at the current pointer.
  always_comb begin
    sel   = rr_pick(MAX_CH'(req), rr_ptr, NCH);
    found = sel.found;
    pick  = sel.idx;
  end

  // Pointer moves past the channel that just completed a full block.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rr_ptr <= '0;
    end else if (adv) begin
      rr_ptr <= (last_id == 4'(NCH-1)) ? '0 : last_id + 4'd1;
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// Write-side scheduler for the shared readout FIFO: one header plus a fixed-size
// payload block per grant, channels served in round-robin order.
module fifo_wr_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned BLOCKSIZE  = 64,
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned MARGIN     = 2
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [NCH-1:0]   ch_req,
  input  logic [NCH-1:0]   ch_valid,
  input  logic [8*NCH-1:0] ch_data,
  output logic [NCH-1:0]   ch_ready,
  output logic [NCH-1:0]   ch_abort,
  input  logic [9:0]       wrcnt,
  input  logic             fifoClr,
  output logic             fifoWr,
  output logic [7:0]       wdata,
  output logic [3:0]       grant_id,
  output logic             busy
);

  localparam int unsigned CW = $clog2(BLOCKSIZE);

  sched_state_t   state, state_nxt;
  logic [CW-1:0]  bytecnt;
  logic [10:0]    need;
  logic           space_ok;
  logic           room;
  logic           arb_found;
  logic [3:0]     arb_pick;
  logic [NCH-1:0] gid_oh;
  logic           hs;
  logic [7:0]     sel_data;
  logic           last_hs;
  logic           grant_done;

  assign need     = {1'b0, wrcnt} + 11'(BLOCKSIZE + 1 + MARGIN);
  assign space_ok = (need <= 11'(FIFO_DEPTH));
  assign room     = ({1'b0, wrcnt} < 11'(FIFO_DEPTH - 1));

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .clk     (clk),
    .arstn   (arstn),
    .req     (ch_req),
    .adv     (grant_done),
    .last_id (grant_id),
    .found   (arb_found),
    .pick    (arb_pick)
  );

  // Decode the granted channel and select its valid/data without a variable-width index.
  always_comb begin
    gid_oh   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant_id == 4'(i)) begin
        gid_oh[i] = 1'b1;
        sel_data  = ch_data[8*i +: 8];
      end
    end
    hs         = |(ch_valid & ch_ready);
    last_hs    = hs && (bytecnt == CW'(BLOCKSIZE - 1));
    grant_done = (state == DATA_s) && last_hs && !fifoClr;
  end

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= IDLE_s;
    else        state <= state_nxt;
  end

  // Next state: a FIFO clear overrides everything, including the final handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_s: if (!fifoClr && space_ok && arb_found) state_nxt = HDR_s;
      HDR_s:  state_nxt = fifoClr ? IDLE_s : DATA_s;
      DATA_s: if (fifoClr || last_hs) state_nxt = IDLE_s;
      default: state_nxt = IDLE_s;
    endcase
  end

  // Combinational outputs: accept strobe to the granted channel while the FIFO has a free slot.
  always_comb begin
    busy     = (state != IDLE_s);
    ch_ready = (state == DATA_s && room) ? gid_oh : '0;
  end

  // Registered datapath: grant latch, FIFO write port, byte counter, abort pulse.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      grant_id <= '0;
      fifoWr   <= 1'b0;
      wdata    <= '0;
      bytecnt  <= '0;
      ch_abort <= '0;
    end else begin
      fifoWr   <= 1'b0;
      ch_abort <= '0;
      case (state)
        IDLE_s: begin
          if (state_nxt == HDR_s) grant_id <= arb_pick;
        end
        HDR_s: begin
          if (fifoClr) begin
            ch_abort <= gid_oh;
          end else begin
            fifoWr  <= 1'b1;
            wdata   <= {HDR_SYNC, grant_id};
            bytecnt <= '0;
          end
        end
        DATA_s: begin
          if (fifoClr) begin
            ch_abort <= gid_oh;
          end else if (hs) begin
            fifoWr  <= 1'b1;
            wdata   <= sel_data;
            bytecnt <= bytecnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Randomised scoreboard bench for fifo_wr_sched with a block-level reference model.
module tb_fifo_wr_sched;

  localparam int NCH = 4;
  localparam int BS  = 4;

  logic             clk = 1'b0;
  logic             arstn = 1'b0;
  logic [NCH-1:0]   ch_req = '0;
  logic [NCH-1:0]   ch_valid;
  logic [8*NCH-1:0] ch_data;
  logic [NCH-1:0]   ch_ready;
  logic [NCH-1:0]   ch_abort;
  logic [9:0]       wrcnt = '0;
  logic             fifoClr = 1'b0;
  logic             fifoWr;
  logic [7:0]       wdata;
  logic [3:0]       grant_id;
  logic             busy;

  fifo_wr_sched #(
    .NCH        (NCH),
    .BLOCKSIZE  (BS),
    .FIFO_DEPTH (1024),
    .MARGIN     (2)
  ) dut (
    .clk      (clk),
    .arstn    (arstn),
    .ch_req   (ch_req),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .ch_abort (ch_abort),
    .wrcnt    (wrcnt),
    .fifoClr  (fifoClr),
    .fifoWr   (fifoWr),
    .wdata    (wdata),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tab[NCH][32][BS];
  int         cnt[NCH]  = '{default: 0};
  int         blk[NCH]  = '{default: 0};
  int         mblk[NCH] = '{default: 0};
  int         mptr = 0;
  bit         rand_valid = 1'b0;
  bit         rand_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference round-robin rule: first requester at or after ptr, modulo NCH.
  function automatic int rr_next(input logic [NCH-1:0] m, input int p);
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (p + k) % NCH;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  // Expected FIFO contents for one grant: header then the first n bytes of the channel's block.
  task automatic push_block(input int ch, input int n);
    exp_q.push_back({4'hA, 4'(ch)});
    for (int i = 0; i < n; i++) exp_q.push_back(tab[ch][mblk[ch] % 32][i]);
    if (n == BS) begin
      mblk[ch]++;
      mptr = (ch + 1) % NCH;
    end
  endtask

  task automatic wait_busy();
    int t = 0;
    while (!busy && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("grant_seen", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("block_end_seen", 32'(busy), 32'd0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_cnt(input int ch, input int n);
    int t = 0;
    while (cnt[ch] != n && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cnt_reach", 32'(cnt[ch]), 32'(n));
  endtask

  task automatic run_block(input logic [NCH-1:0] mask);
    push_block(rr_next(mask, mptr), BS);
    @(negedge clk);
    ch_req = mask;
    wait_busy();
    @(negedge clk);
    ch_req = '0;
    wait_drain();
  endtask

  // Channel sources: present the next byte of the current block, advance on handshake,
  // rewind the block on abort or reset.
  initial begin
    ch_valid = '0;
    ch_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (!arstn || ch_abort[i]) cnt[i] = 0;
        ch_valid[i] = rand_valid ? ($urandom_range(0, 99) < 70) : 1'b1;
        ch_data[8*i +: 8] = tab[i][blk[i] % 32][cnt[i]];
      end
      if (rand_wr) wrcnt = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 900));
      #4;
      for (int i = 0; i < NCH; i++) begin
        if (arstn && !fifoClr && ch_valid[i] && ch_ready[i]) begin
          cnt[i]++;
          if (cnt[i] == BS) begin
            cnt[i] = 0;
            blk[i]++;
          end
        end
      end
    end
  end

  // Monitor: every FIFO write is popped from the scoreboard and compared.
  initial begin : mon
    logic [7:0] e;
    forever begin
      @(posedge clk); #1;
      if (arstn && fifoWr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h expected none", wdata);
        end else begin
          e = exp_q.pop_front();
          chk("fifo_byte", 32'(wdata), 32'(e));
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < 32; b++)
        for (int i = 0; i < BS; i++) tab[c][b][i] = 8'($urandom);
    tab[1][0][0] = 8'h11;
    tab[1][0][1] = 8'h22;
    tab[1][0][2] = 8'h33;
    tab[1][0][3] = 8'h44;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_fifoWr", 32'(fifoWr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ch_ready", 32'(ch_ready), 0);
    chk("rst_ch_abort", 32'(ch_abort), 0);
    @(negedge clk);
    arstn = 1'b1;

    // Single channel with known bytes, then pointer must sit at channel 2.
    run_block(4'b0010);
    run_block(4'b0110);

    // Held requests on all channels: five consecutive blocks in rotation.
    rand_valid = 1'b1;
    for (int b = 0; b < 5; b++) push_block(rr_next(4'b1111, mptr), BS);
    @(negedge clk);
    ch_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_busy();
      if (n < 4) wait_idle();
    end
    @(negedge clk);
    ch_req = '0;
    wait_drain();
    rand_valid = 1'b0;

    // Space gating at the exact boundary.
    begin
      bit saw = 1'b0;
      @(negedge clk);
      wrcnt  = 10'd1018;
      ch_req = 4'b0001;
      repeat (10) begin
        @(posedge clk); #1;
        if (busy) saw = 1'b1;
      end
      chk("space_block_1018", 32'(saw), 0);
      push_block(rr_next(4'b0001, mptr), BS);
      @(negedge clk);
      wrcnt = 10'd1017;
      wait_busy();
      @(negedge clk);
      ch_req = '0;
      wait_drain();
      wrcnt = '0;
    end

    // Stall with the FIFO one short of full after two payload bytes.
    push_block(rr_next(4'b1000, mptr), BS);
    @(negedge clk);
    ch_req = 4'b1000;
    wait_busy();
    @(negedge clk);
    ch_req = '0;
    wait_cnt(3, 2);
    wrcnt = 10'd1023;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_ch_ready", 32'(ch_ready), 0);
      chk("stall_fifoWr", 32'(fifoWr), 0);
    end
    @(negedge clk);
    wrcnt = '0;
    wait_drain();

    // Clear during the third payload handshake of channel 2.
    push_block(2, 2);
    @(negedge clk);
    ch_req = 4'b0100;
    wait_busy();
    @(negedge clk);
    ch_req = '0;
    wait_cnt(2, 2);
    fifoClr = 1'b1;
    @(posedge clk); #1;
    chk("abort_pulse_ch2", 32'(ch_abort), 32'h4);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk);
    fifoClr = 1'b0;
    @(posedge clk); #1;
    chk("abort_one_cycle", 32'(ch_abort), 0);
    wait_drain();
    run_block(4'b1100);

    // Clear coinciding with the final handshake.
    push_block(0, BS - 1);
    @(negedge clk);
    ch_req = 4'b0001;
    wait_busy();
    @(negedge clk);
    ch_req = '0;
    wait_cnt(0, BS - 1);
    fifoClr = 1'b1;
    @(posedge clk); #1;
    chk("abort_pulse_last", 32'(ch_abort), 32'h1);
    @(negedge clk);
    fifoClr = 1'b0;
    @(posedge clk); #1;
    chk("abort_last_one_cycle", 32'(ch_abort), 0);
    wait_drain();

    // Reset in the middle of a block: no abort pulse, pointer back to 0.
    push_block(1, 2);
    @(negedge clk);
    ch_req = 4'b0010;
    wait_busy();
    @(negedge clk);
    ch_req = '0;
    wait_cnt(1, 2);
    arstn = 1'b0;
    #1;
    chk("midrst_fifoWr", 32'(fifoWr), 0);
    chk("midrst_busy", 32'(busy), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_abort", 32'(ch_abort), 0);
    end
    @(negedge clk);
    arstn = 1'b1;
    mptr  = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("postrst_no_abort", 32'(ch_abort), 0);
      chk("postrst_no_write", 32'(fifoWr), 0);
    end
    wait_drain();
    run_block(4'b1111);

    // Random request masks, random valid and random FIFO occupancy.
    rand_valid = 1'b1;
    rand_wr    = 1'b1;
    repeat (20) run_block(4'($urandom_range(1, 15)));
    rand_wr    = 1'b0;
    rand_valid = 1'b0;
    @(negedge clk);
    wrcnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
